// File: rtl/import_resolve_sched.sv
// Package-import resolution scheduler: per-package name table, one package
// scanned per cycle, reports resolving package or wildcard/export conflict.
// Ports: clk, rst_n (sync, active-low); wc_en; cfg_we/pkg/name/val, cfg_ready;
// req_valid/ready, req_name/explicit/pkg; rsp_valid/ready, rsp_found/pkg,
// rsp_conflict/conflict_pkg. Define RESOLVE_STATS_EN for stat_lookups and
// stat_conflicts saturating counters.
module import_resolve_sched #(
    parameter int NUM_PKG = 4,
    parameter int NAME_W  = 8,
    parameter int PKG_W   = $clog2(NUM_PKG)
) (
`ifdef RESOLVE_STATS_EN
    output logic [15:0]        stat_lookups,
    output logic [15:0]        stat_conflicts,
`endif
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_PKG-1:0] wc_en,
    input  logic               cfg_we,
    input  logic [PKG_W-1:0]   cfg_pkg,
    input  logic [NAME_W-1:0]  cfg_name,
    input  logic               cfg_val,
    output logic               cfg_ready,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NAME_W-1:0]  req_name,
    input  logic               req_explicit,
    input  logic [PKG_W-1:0]   req_pkg,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_found,
    output logic [PKG_W-1:0]   rsp_pkg,
    output logic               rsp_conflict,
    output logic [PKG_W-1:0]   rsp_conflict_pkg
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [PKG_W:0] LAST = (PKG_W+1)'(NUM_PKG);

    logic [NUM_PKG-1:0][2**NAME_W-1:0] tbl_q;

    state_t              state_q;
    logic [PKG_W:0]      cnt_q;
    logic                hv_q, hit_q;
    logic [PKG_W-1:0]    hk_q;
    logic [NUM_PKG-1:0]  wc_q;
    logic [NAME_W-1:0]   name_q;
    logic                exp_q;
    logic [PKG_W-1:0]    rpkg_q;
    logic                f_v_q, s_v_q, own_q;
    logic [PKG_W-1:0]    f_pkg_q, s_pkg_q;
    logic                f_v_d, s_v_d, own_d;
    logic [PKG_W-1:0]    f_pkg_d, s_pkg_d;
    logic                fin_found, fin_conf;
    logic [PKG_W-1:0]    fin_pkg, fin_cpkg;

    logic                req_ready_q, cfg_ready_q, rsp_valid_q;
    logic                rsp_found_q, rsp_conflict_q;
    logic [PKG_W-1:0]    rsp_pkg_q, rsp_cpkg_q;
`ifdef RESOLVE_STATS_EN
    logic [15:0]         lk_q, cf_q;
`endif

    // Writes are only honoured in IDLE so a scan always sees a frozen table.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_q <= '0;
        end else if (cfg_we && cfg_ready_q) begin
            tbl_q[cfg_pkg][cfg_name] <= cfg_val;
        end
    end

    // Table bit read in one SCAN cycle is folded in the next (hv_q/hit_q),
    // which is why the scan takes one drain cycle after the last package.
    // In explicit mode the requested package is tracked separately (own)
    // and f_* collects only competing wildcard candidates.
    always_comb begin
        f_v_d   = f_v_q;
        f_pkg_d = f_pkg_q;
        s_v_d   = s_v_q;
        s_pkg_d = s_pkg_q;
        own_d   = own_q;
        if (hv_q) begin
            if (exp_q && hk_q == rpkg_q) begin
                own_d = hit_q;
            end else if (hit_q && wc_q[hk_q]) begin
                if (!f_v_q) begin
                    f_v_d   = 1'b1;
                    f_pkg_d = hk_q;
                end else if (!s_v_q) begin
                    s_v_d   = 1'b1;
                    s_pkg_d = hk_q;
                end
            end
        end
    end

    always_comb begin
        fin_found = exp_q ? own_d : f_v_d;
        fin_pkg   = exp_q ? (own_d ? rpkg_q : '0) : f_pkg_d;
        fin_conf  = exp_q ? (own_d & f_v_d) : s_v_d;
        fin_cpkg  = exp_q ? (fin_conf ? f_pkg_d : '0) : s_pkg_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            hv_q           <= 1'b0;
            hit_q          <= 1'b0;
            hk_q           <= '0;
            wc_q           <= '0;
            name_q         <= '0;
            exp_q          <= 1'b0;
            rpkg_q         <= '0;
            f_v_q          <= 1'b0;
            s_v_q          <= 1'b0;
            own_q          <= 1'b0;
            f_pkg_q        <= '0;
            s_pkg_q        <= '0;
            req_ready_q    <= 1'b1;
            cfg_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_found_q    <= 1'b0;
            rsp_pkg_q      <= '0;
            rsp_conflict_q <= 1'b0;
            rsp_cpkg_q     <= '0;
`ifdef RESOLVE_STATS_EN
            lk_q           <= '0;
            cf_q           <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q     <= SCAN;
                        cnt_q       <= '0;
                        hv_q        <= 1'b0;
                        wc_q        <= wc_en;
                        name_q      <= req_name;
                        exp_q       <= req_explicit;
                        rpkg_q      <= req_pkg;
                        f_v_q       <= 1'b0;
                        s_v_q       <= 1'b0;
                        own_q       <= 1'b0;
                        f_pkg_q     <= '0;
                        s_pkg_q     <= '0;
                        req_ready_q <= 1'b0;
                        cfg_ready_q <= 1'b0;
                    end
                end
                SCAN: begin
                    f_v_q   <= f_v_d;
                    f_pkg_q <= f_pkg_d;
                    s_v_q   <= s_v_d;
                    s_pkg_q <= s_pkg_d;
                    own_q   <= own_d;
                    if (cnt_q == LAST) begin
                        hv_q           <= 1'b0;
                        state_q        <= DONE;
                        rsp_valid_q    <= 1'b1;
                        rsp_found_q    <= fin_found;
                        rsp_pkg_q      <= fin_pkg;
                        rsp_conflict_q <= fin_conf;
                        rsp_cpkg_q     <= fin_cpkg;
                    end else begin
                        hit_q <= tbl_q[cnt_q[PKG_W-1:0]][name_q];
                        hk_q  <= cnt_q[PKG_W-1:0];
                        hv_q  <= 1'b1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        cfg_ready_q <= 1'b1;
`ifdef RESOLVE_STATS_EN
                        if (lk_q != 16'hFFFF) lk_q <= lk_q + 16'd1;
                        if (rsp_conflict_q && cf_q != 16'hFFFF)
                            cf_q <= cf_q + 16'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready        = req_ready_q;
    assign cfg_ready        = cfg_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_found        = rsp_found_q;
    assign rsp_pkg          = rsp_pkg_q;
    assign rsp_conflict     = rsp_conflict_q;
    assign rsp_conflict_pkg = rsp_cpkg_q;
`ifdef RESOLVE_STATS_EN
    assign stat_lookups     = lk_q;
    assign stat_conflicts   = cf_q;
`endif

endmodule

// File: tb/tb_import_resolve_sched.sv
// Directed bench for import_resolve_sched: table writes, wildcard/explicit
// lookups, latency, backpressure, dropped writes, reset mid-scan, stats.
module tb_import_resolve_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] wc_en;
    logic       cfg_we;
    logic [1:0] cfg_pkg;
    logic [7:0] cfg_name;
    logic       cfg_val;
    logic       cfg_ready;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_name;
    logic       req_explicit;
    logic [1:0] req_pkg;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_found;
    logic [1:0] rsp_pkg;
    logic       rsp_conflict;
    logic [1:0] rsp_conflict_pkg;
`ifdef RESOLVE_STATS_EN
    logic [15:0] stat_lookups;
    logic [15:0] stat_conflicts;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    import_resolve_sched dut (
`ifdef RESOLVE_STATS_EN
        .stat_lookups    (stat_lookups),
        .stat_conflicts  (stat_conflicts),
`endif
        .clk             (clk),
        .rst_n           (rst_n),
        .wc_en           (wc_en),
        .cfg_we          (cfg_we),
        .cfg_pkg         (cfg_pkg),
        .cfg_name        (cfg_name),
        .cfg_val         (cfg_val),
        .cfg_ready       (cfg_ready),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_name        (req_name),
        .req_explicit    (req_explicit),
        .req_pkg         (req_pkg),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_found       (rsp_found),
        .rsp_pkg         (rsp_pkg),
        .rsp_conflict    (rsp_conflict),
        .rsp_conflict_pkg(rsp_conflict_pkg)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] p, input logic [7:0] n,
                             input logic v);
        cfg_we   = 1'b1;
        cfg_pkg  = p;
        cfg_name = n;
        cfg_val  = v;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!rsp_valid) chk({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic lookup(input string tag, input logic ex,
                          input logic [1:0] pk, input logic [7:0] nm,
                          input logic [3:0] wc, input logic ef,
                          input logic [1:0] ep, input logic ec,
                          input logic [1:0] ecp);
        int lat;
        req_valid    = 1'b1;
        req_explicit = ex;
        req_pkg      = pk;
        req_name     = nm;
        wc_en        = wc;
        tick();
        req_valid    = 1'b0;
        wc_en        = 4'b0000;
        wait_rsp(tag, lat);
        chk({tag, ".lat"}, lat, 5);
        chk({tag, ".found"}, rsp_found, ef);
        chk({tag, ".pkg"}, rsp_pkg, ep);
        chk({tag, ".conf"}, rsp_conflict, ec);
        chk({tag, ".cpkg"}, rsp_conflict_pkg, ecp);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int rose;
        rst_n = 1'b0; wc_en = '0; cfg_we = 0; cfg_pkg = '0; cfg_name = '0;
        cfg_val = 0; req_valid = 0; req_name = '0; req_explicit = 0;
        req_pkg = '0; rsp_ready = 0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst.req_ready", req_ready, 1);
        chk("rst.cfg_ready", cfg_ready, 1);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.found", rsp_found, 0);
        chk("rst.pkg", rsp_pkg, 0);
        chk("rst.conf", rsp_conflict, 0);
        chk("rst.cpkg", rsp_conflict_pkg, 0);
`ifdef RESOLVE_STATS_EN
        chk("rst.stat_lk", stat_lookups, 0);
        chk("rst.stat_cf", stat_conflicts, 0);
`endif

        cfg_write(2'd0, 8'h12, 1'b1);
        cfg_write(2'd1, 8'h12, 1'b1);
        lookup("export", 1, 2'd0, 8'h12, 4'b0011, 1, 2'd0, 1, 2'd1);

        cfg_write(2'd2, 8'h40, 1'b1);
        lookup("single", 0, 2'd0, 8'h40, 4'b1111, 1, 2'd2, 0, 2'd0);

        cfg_write(2'd1, 8'h07, 1'b1);
        cfg_write(2'd3, 8'h07, 1'b1);
        lookup("mask1", 0, 2'd0, 8'h07, 4'b0010, 1, 2'd1, 0, 2'd0);
        lookup("mask2", 0, 2'd0, 8'h07, 4'b1010, 1, 2'd1, 1, 2'd3);

        cfg_write(2'd3, 8'h12, 1'b1);
        lookup("three", 0, 2'd0, 8'h12, 4'b1111, 1, 2'd0, 1, 2'd1);
        lookup("exp_miss", 1, 2'd2, 8'h12, 4'b1111, 0, 2'd0, 0, 2'd0);
        lookup("exp_own_off", 1, 2'd3, 8'h07, 4'b0010, 1, 2'd3, 1, 2'd1);
        lookup("none", 0, 2'd0, 8'h99, 4'b1111, 0, 2'd0, 0, 2'd0);

        // Backpressure with a dropped write issued mid-scan.
        req_valid = 1; req_explicit = 0; req_name = 8'h07; wc_en = 4'b1010;
        tick();
        req_valid = 0; wc_en = 4'b0000;
        chk("bp.cfg_ready", cfg_ready, 0);
        cfg_write(2'd2, 8'h55, 1'b1);
        wait_rsp("bp", lat);
        for (int i = 0; i < 10; i++) begin
            chk("bp.valid", rsp_valid, 1);
            chk("bp.req_ready", req_ready, 0);
            chk("bp.found", rsp_found, 1);
            chk("bp.pkg", rsp_pkg, 1);
            chk("bp.conf", rsp_conflict, 1);
            chk("bp.cpkg", rsp_conflict_pkg, 3);
            tick();
        end
        rsp_ready = 1; tick(); rsp_ready = 0;
        lookup("dropped", 0, 2'd0, 8'h55, 4'b1111, 0, 2'd0, 0, 2'd0);

        // Write and accept on the same edge: lookup sees the new entry.
        cfg_we = 1; cfg_pkg = 2'd1; cfg_name = 8'h66; cfg_val = 1;
        lookup("same_edge", 0, 2'd0, 8'h66, 4'b1111, 1, 2'd1, 0, 2'd0);
        cfg_we = 0;
        lookup("removed_chk", 0, 2'd0, 8'h66, 4'b0001, 0, 2'd0, 0, 2'd0);

        // rsp_ready held high: single-cycle valid, IDLE right after.
        rsp_ready = 1;
        req_valid = 1; req_explicit = 0; req_name = 8'h40; wc_en = 4'b1111;
        tick();
        req_valid = 0;
        wait_rsp("hold", lat);
        chk("hold.lat", lat, 5);
        tick();
        chk("hold.valid_drop", rsp_valid, 0);
        chk("hold.req_ready", req_ready, 1);
        rsp_ready = 0;

        // Reset while scanning package index 2.
        req_valid = 1; req_explicit = 0; req_name = 8'h40; wc_en = 4'b1111;
        tick();
        req_valid = 0;
        tick(); tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mrst.req_ready", req_ready, 1);
        chk("mrst.found", rsp_found, 0);
        rose = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) rose++;
            tick();
        end
        chk("mrst.no_rsp", rose, 0);
        lookup("mrst.40", 0, 2'd0, 8'h40, 4'b1111, 0, 2'd0, 0, 2'd0);
        lookup("mrst.12", 0, 2'd0, 8'h12, 4'b1111, 0, 2'd0, 0, 2'd0);

`ifdef RESOLVE_STATS_EN
        cfg_write(2'd0, 8'h12, 1'b1);
        cfg_write(2'd1, 8'h12, 1'b1);
        lookup("st.conf", 0, 2'd0, 8'h12, 4'b0011, 1, 2'd0, 1, 2'd1);
        chk("stat_lookups", stat_lookups, 3);
        chk("stat_conflicts", stat_conflicts, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
